exec_unit: RTL



---
 rtl/exec_unit.sv | 279 +++++++++++++++++++++++++++
 1 files changed

// File: rtl/exec_unit.sv
// exec_unit: RISC-V integer execute unit.
//   ALU and BRANCH ops complete one cycle after accept. MULDIV ops use
//   XLEN-step iterative engines: shift-add multiply and restoring divide,
//   both working on operand magnitudes. Divide-by-zero and signed overflow
//   are resolved in one cycle without entering the DIV state.
// Ports:
//   clk, resetn          clock, synchronous active-low reset
//   in_valid / in_ready  request handshake (op_class, funct3, alt, x, y)
//   out_valid/out_ready  result handshake (result, taken, illegal)
//   busy                 an iterative MUL/DIV is in progress
module exec_unit #(
  parameter int unsigned XLEN     = 32,
  parameter bit          ENABLE_M = 1'b1
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [1:0]      op_class,
  input  logic [2:0]      funct3,
  input  logic            alt,
  input  logic [XLEN-1:0] x,
  input  logic [XLEN-1:0] y,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            taken,
  output logic            illegal,
  output logic            busy
);

  localparam int unsigned SHW = $clog2(XLEN);
  localparam int unsigned DW  = 2 * XLEN;
  localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV} state_t;

  state_t          state_q, state_d;
  logic [SHW-1:0]  cnt_q, cnt_d;
  logic [2:0]      f3_q, f3_d;
  logic            neg_q, neg_d;    // negate product / quotient at the end
  logic            negr_q, negr_d;  // negate remainder at the end
  logic [DW-1:0]   acc_q, acc_d;
  logic [DW-1:0]   mcand_q, mcand_d;
  logic [XLEN-1:0] mplr_q, mplr_d;
  logic [XLEN-1:0] quo_q, quo_d;
  logic [XLEN-1:0] rem_q, rem_d;
  logic [XLEN-1:0] dvsr_q, dvsr_d;
  logic            out_valid_q, out_valid_d;
  logic [XLEN-1:0] result_q, result_d;
  logic            taken_q, taken_d;
  logic            illegal_q, illegal_d;

  function automatic logic [XLEN-1:0] mag(input logic [XLEN-1:0] v, input logic s);
    return (s && v[XLEN-1]) ? -v : v;
  endfunction

  // Single-cycle ALU and branch compare on the live request operands.
  logic [SHW-1:0]  shamt;
  logic            lt_s, lt_u, eq;
  logic [XLEN-1:0] alu_res;
  logic            br_taken, br_ill;

  assign shamt = y[SHW-1:0];
  assign lt_s  = $signed(x) < $signed(y);
  assign lt_u  = x < y;
  assign eq    = x == y;

  always_comb begin
    alu_res = '0;
    unique case (funct3)
      3'b000: alu_res = alt ? (x - y) : (x + y);
      3'b001: alu_res = x << shamt;
      3'b010: alu_res = {{(XLEN-1){1'b0}}, lt_s};
      3'b011: alu_res = {{(XLEN-1){1'b0}}, lt_u};
      3'b100: alu_res = x ^ y;
      3'b101: begin
        // kept as separate assignments so the arithmetic shift stays signed
        if (alt) alu_res = $signed(x) >>> shamt;
        else     alu_res = x >> shamt;
      end
      3'b110: alu_res = x | y;
      default: alu_res = x & y;
    endcase
  end

  always_comb begin
    br_taken = 1'b0;
    br_ill   = 1'b0;
    unique case (funct3)
      3'b000: br_taken = eq;
      3'b001: br_taken = !eq;
      3'b100: br_taken = lt_s;
      3'b101: br_taken = !lt_s;
      3'b110: br_taken = lt_u;
      3'b111: br_taken = !lt_u;
      default: br_ill  = 1'b1;
    endcase
  end

  // MULDIV operand preparation.
  logic            x_sgn, y_sgn, md_ovf;
  logic [XLEN-1:0] mx, my;

  always_comb begin
    if (!funct3[2]) begin
      x_sgn = (funct3 == 3'b001) || (funct3 == 3'b010);
      y_sgn = (funct3 == 3'b001);
    end else begin
      x_sgn = !funct3[0];
      y_sgn = !funct3[0];
    end
  end

  assign mx     = mag(x, x_sgn);
  assign my     = mag(y, y_sgn);
  assign md_ovf = !funct3[0] && (x == MOST_NEG) && (y == '1);

  // One shift-add step and one restoring-divide step.
  logic [DW-1:0]   acc_step, prod_fin;
  logic [XLEN:0]   div_sh, div_diff;
  logic            div_ge;
  logic [XLEN-1:0] rem_step, quo_step;

  assign acc_step = acc_q + (mplr_q[0] ? mcand_q : '0);
  assign prod_fin = neg_q ? -acc_step : acc_step;
  assign div_sh   = {rem_q, quo_q[XLEN-1]};
  assign div_diff = div_sh - {1'b0, dvsr_q};
  assign div_ge   = !div_diff[XLEN];
  assign rem_step = div_ge ? div_diff[XLEN-1:0] : div_sh[XLEN-1:0];
  assign quo_step = {quo_q[XLEN-2:0], div_ge};

  logic accept;
  assign in_ready = (state_q == S_IDLE) && (!out_valid_q || out_ready);
  assign accept   = in_valid && in_ready;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    f3_d        = f3_q;
    neg_d       = neg_q;
    negr_d      = negr_q;
    acc_d       = acc_q;
    mcand_d     = mcand_q;
    mplr_d      = mplr_q;
    quo_d       = quo_q;
    rem_d       = rem_q;
    dvsr_d      = dvsr_q;
    out_valid_d = out_valid_q;
    result_d    = result_q;
    taken_d     = taken_q;
    illegal_d   = illegal_q;

    if (out_ready) begin
      out_valid_d = 1'b0;
      result_d    = '0;
      taken_d     = 1'b0;
      illegal_d   = 1'b0;
    end

    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          f3_d = funct3;
          unique case (op_class)
            2'b00: begin
              out_valid_d = 1'b1;
              result_d    = alu_res;
              taken_d     = 1'b0;
              illegal_d   = 1'b0;
            end
            2'b01: begin
              out_valid_d = 1'b1;
              result_d    = '0;
              taken_d     = br_taken;
              illegal_d   = br_ill;
            end
            2'b10: begin
              if (!ENABLE_M) begin
                out_valid_d = 1'b1;
                result_d    = '0;
                taken_d     = 1'b0;
                illegal_d   = 1'b1;
              end else if (!funct3[2]) begin
                state_d = S_MUL;
                cnt_d   = '0;
                acc_d   = '0;
                mcand_d = {{XLEN{1'b0}}, mx};
                mplr_d  = my;
                neg_d   = (x_sgn && x[XLEN-1]) ^ (y_sgn && y[XLEN-1]);
              end else if ((y == '0) || md_ovf) begin
                out_valid_d = 1'b1;
                taken_d     = 1'b0;
                illegal_d   = 1'b0;
                if (y == '0) result_d = funct3[1] ? x : '1;
                else         result_d = funct3[1] ? '0 : x;
              end else begin
                state_d = S_DIV;
                cnt_d   = '0;
                quo_d   = mx;
                rem_d   = '0;
                dvsr_d  = my;
                neg_d   = x_sgn && (x[XLEN-1] ^ y[XLEN-1]);
                negr_d  = x_sgn && x[XLEN-1];
              end
            end
            default: begin
              out_valid_d = 1'b1;
              result_d    = '0;
              taken_d     = 1'b0;
              illegal_d   = 1'b1;
            end
          endcase
        end
      end
      S_MUL: begin
        acc_d   = acc_step;
        mcand_d = mcand_q << 1;
        mplr_d  = mplr_q >> 1;
        cnt_d   = cnt_q + SHW'(1);
        if (cnt_q == SHW'(XLEN - 1)) begin
          state_d     = S_IDLE;
          out_valid_d = 1'b1;
          result_d    = (f3_q == 3'b000) ? prod_fin[XLEN-1:0] : prod_fin[DW-1:XLEN];
          taken_d     = 1'b0;
          illegal_d   = 1'b0;
        end
      end
      S_DIV: begin
        quo_d = quo_step;
        rem_d = rem_step;
        cnt_d = cnt_q + SHW'(1);
        if (cnt_q == SHW'(XLEN - 1)) begin
          state_d     = S_IDLE;
          out_valid_d = 1'b1;
          if (f3_q[1]) result_d = negr_q ? -rem_step : rem_step;
          else         result_d = neg_q ? -quo_step : quo_step;
          taken_d     = 1'b0;
          illegal_d   = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      taken_q     <= 1'b0;
      illegal_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
      taken_q     <= taken_d;
      illegal_q   <= illegal_d;
    end
    f3_q    <= f3_d;
    neg_q   <= neg_d;
    negr_q  <= negr_d;
    acc_q   <= acc_d;
    mcand_q <= mcand_d;
    mplr_q  <= mplr_d;
    quo_q   <= quo_d;
    rem_q   <= rem_d;
    dvsr_q  <= dvsr_d;
  end

  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign taken     = taken_q;
  assign illegal   = illegal_q;
  assign busy      = state_q != S_IDLE;

endmodule
